// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues imem requests, presents instructions to decode, squashes wrong-path fetches.
// Optional FETCH_PERF_EN adds fetch_count/squash_count performance counters.
module fetch_pc_unit #(
  parameter int                  WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                redirect_valid,
  input  logic [WordSize-1:0] redirect_addr,
  input  logic                stall,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                out_valid,
  output logic [WordSize-1:0] out_pc,
  output logic [WordSize-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         squash_count
`endif
);

  // state | meaning
  // IDLE  | out of reset, no request yet
  // REQ   | request for pc outstanding
  // HOLD  | response parked in hold, waiting for a free output slot
  // DRAIN | squashed request still outstanding, next pc parked in tgt
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [WordSize-1:0] tgt_q, tgt_d;
  logic [WordSize-1:0] hold_q, hold_d;
  logic                out_valid_q, out_valid_d;
  logic [WordSize-1:0] out_pc_q, out_pc_d;
  logic [WordSize-1:0] out_instr_q, out_instr_d;
  logic                slot_free;

  assign slot_free = !out_valid_q || !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    hold_d      = hold_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    // Redirect marks the slot content as wrong-path, even while decode stalls.
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid && imem_ack) begin
          pc_d = redirect_addr;
        end else if (redirect_valid) begin
          tgt_d   = redirect_addr;
          state_d = DRAIN;
        end else if (imem_ack) begin
          if (slot_free) begin
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata;
            out_valid_d = 1'b1;
            pc_d        = pc_q + WordSize'(4);
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          state_d = REQ;
        end else if (!stall) begin
          out_pc_d    = pc_q;
          out_instr_d = hold_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + WordSize'(4);
          state_d     = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_addr : tgt_q;
          state_d = REQ;
        end else if (redirect_valid) begin
          tgt_d = redirect_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pc_q        <= ResetVector;
      tgt_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

`ifdef FETCH_PERF_EN
  logic fetch_load;
  logic squash;

  assign fetch_load = (state_q == REQ && imem_ack && !redirect_valid && slot_free) ||
                      (state_q == HOLD && !redirect_valid && !stall);
  assign squash     = (state_q == REQ && imem_ack && redirect_valid) ||
                      (state_q == DRAIN && imem_ack) ||
                      (state_q == HOLD && redirect_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (fetch_load) fetch_count <= fetch_count + 32'd1;
      if (squash) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule
